out_capture_uart: RTL

OUT_CAPTURE_UART -- requirements
Module: out_capture_uart

---
 rtl/out_capture_uart.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/out_capture_uart.sv
// Byte capture FIFO draining into an 8N1 serial transmitter.
// Bytes strobed in on din_valid are queued and sent LSB first on tx.
module out_capture_uart #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [7:0]               din,
    input  logic                     din_valid,
    output logic                     tx,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_d;
    logic             push;
    logic             drop;
    logic             pop;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] clk_cnt_d;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_d;
    logic [7:0]       shift;
    logic [7:0]       shift_d;
    logic             tx_d;
    logic             busy_d;
    logic             bit_end;

    // Push/drop decisions use the registered full flag only.
    assign push    = ena & din_valid & ~full;
    assign drop    = ena & din_valid & full;
    assign bit_end = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + CW'(1);
        end else if (!push && pop) begin
            count_d = count - CW'(1);
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == CW'(0));
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Transmitter state and registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            clk_cnt <= clk_cnt_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            tx      <= tx_d;
            busy    <= busy_d;
        end
    end

    // Next state; tx/busy are decoded from the next state so they register with it.
    always_comb begin
        state_d   = state;
        clk_cnt_d = clk_cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        pop       = 1'b0;

        unique case (state)
            IDLE: begin
                if (!empty && ena) begin
                    pop       = 1'b1;
                    shift_d   = mem[rd_ptr];
                    clk_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'(1);
                        shift_d   = {1'b0, shift[7:1]};
                    end
                end else begin
                    clk_cnt_d = clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clk_cnt_d = clk_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end
    end

endmodule
